// File: rtl/mor1kx_wb_arb_espresso_if.sv
// Writeback arbiter bus: ALU result port, load issue/return port,
// decode hazard query, registered register-file write and debug view.
// Valid/ready rule: a transfer happens in a cycle exactly when the valid
// (alu_valid_i / ld_issue_i) and the matching ready (alu_ready_o /
// ld_ready_o) are both high at the rising edge; ready is combinational and
// valid may be raised or dropped freely, a transfer is never implied by
// valid alone.
interface mor1kx_wb_arb_espresso_if #(
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int OPTION_OPERAND_WIDTH = 32
);
  logic                            alu_valid_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] alu_rd_i;
  logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i;
  logic                            alu_ready_o;
  logic                            ld_issue_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] ld_rd_i;
  logic                            ld_ready_o;
  logic                            lsu_ack_i;
  logic [OPTION_OPERAND_WIDTH-1:0] lsu_data_i;
  logic                            flush_i;
  logic                            rf_re_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i;
  logic                            stall_o;
  logic                            rf_we_o;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_adr_o;
  logic [OPTION_OPERAND_WIDTH-1:0] result_o;
  // Debug view of the load FSM (0 IDLE, 1 WAIT, 2 DRAIN) and its destination.
  logic [1:0]                      state_o;
  logic [OPTION_RF_ADDR_WIDTH-1:0] pend_rd_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_result_i,
    input  ld_issue_i, ld_rd_i, lsu_ack_i, lsu_data_i, flush_i,
    input  rf_re_i, rfa_adr_i, rfb_adr_i,
    output alu_ready_o, ld_ready_o, stall_o,
    output rf_we_o, rfd_adr_o, result_o,
    output state_o, pend_rd_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_result_i,
    output ld_issue_i, ld_rd_i, lsu_ack_i, lsu_data_i, flush_i,
    output rf_re_i, rfa_adr_i, rfb_adr_i,
    input  alu_ready_o, ld_ready_o, stall_o,
    input  rf_we_o, rfd_adr_o, result_o,
    input  state_o, pend_rd_o
  );
endinterface

// File: rtl/mor1kx_wb_arb_espresso.sv
// Single-port register-file writeback arbiter: one outstanding load tracked
// by a small FSM, a one-entry skid buffer for ALU results that lose the
// write slot, read-hazard stall generation and a registered write port.
module mor1kx_wb_arb_espresso #(
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  mor1kx_wb_arb_espresso_if.slave bus
);
  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int DW = OPTION_OPERAND_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pend_rd_q, pend_rd_d;
  logic            buf_valid_q, buf_valid_d;
  logic [AW-1:0]   buf_rd_q, buf_rd_d;
  logic [DW-1:0]   buf_data_q, buf_data_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rfd_adr_q, rfd_adr_d;
  logic [DW-1:0]   result_q, result_d;

  logic            ld_ready;
  logic            ld_wr;
  logic            ld_accept;
  logic            alu_ready;
  logic            alu_accept;
  logic            grant_valid;
  logic [AW-1:0]   grant_rd;
  logic [DW-1:0]   grant_data;
  logic            hit_pend;
  logic            hit_buf;

  assign ld_accept  = bus.ld_issue_i && ld_ready;
  // A pending load to the same GPR blocks the ALU so writes stay in order.
  assign alu_ready  = !buf_valid_q &&
                      !((state_q == ST_WAIT) && (bus.alu_rd_i == pend_rd_q));
  assign alu_accept = bus.alu_valid_i && alu_ready;

  // FSM state register plus the other arbiter flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_rd_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      rf_we_q     <= 1'b0;
      rfd_adr_q   <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      rf_we_q     <= rf_we_d;
      rfd_adr_q   <= rfd_adr_d;
      result_q    <= result_d;
    end
  end

  // Next-state logic for the load tracker.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (ld_accept) begin
          state_d   = ST_WAIT;
          pend_rd_d = bus.ld_rd_i;
        end
      end
      ST_WAIT: begin
        if (bus.lsu_ack_i) begin
          // A flush in the ack cycle lets this load finish but kills a new issue.
          if (ld_accept && !bus.flush_i) begin
            state_d   = ST_WAIT;
            pend_rd_d = bus.ld_rd_i;
          end else begin
            state_d   = ST_IDLE;
          end
        end else if (bus.flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.lsu_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: load-port ready and load-data write request.
  always_comb begin
    ld_ready = 1'b0;
    ld_wr    = 1'b0;
    case (state_q)
      ST_IDLE: ld_ready = 1'b1;
      ST_WAIT: begin
        ld_ready = bus.lsu_ack_i;
        ld_wr    = bus.lsu_ack_i;
      end
      default: begin
        ld_ready = 1'b0;
        ld_wr    = 1'b0;
      end
    endcase
  end

  // Write-slot arbitration: load data, then buffered ALU, then new ALU.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    grant_valid = 1'b0;
    grant_rd    = '0;
    grant_data  = '0;
    rf_we_d     = 1'b0;
    rfd_adr_d   = rfd_adr_q;
    result_d    = result_q;
    if (ld_wr) begin
      grant_valid = 1'b1;
      grant_rd    = pend_rd_q;
      grant_data  = bus.lsu_data_i;
      if (alu_accept) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = bus.alu_rd_i;
        buf_data_d  = bus.alu_result_i;
      end
    end else if (buf_valid_q) begin
      grant_valid = 1'b1;
      grant_rd    = buf_rd_q;
      grant_data  = buf_data_q;
      buf_valid_d = 1'b0;
    end else if (alu_accept) begin
      grant_valid = 1'b1;
      grant_rd    = bus.alu_rd_i;
      grant_data  = bus.alu_result_i;
    end
    // r0 is hardwired zero: the slot is consumed but nothing is written.
    if (grant_valid && (grant_rd != '0)) begin
      rf_we_d   = 1'b1;
      rfd_adr_d = grant_rd;
      result_d  = grant_data;
    end
  end

  // Read-hazard detection against the pending load and the skid buffer.
  always_comb begin
    hit_pend = (state_q == ST_WAIT) && (pend_rd_q != '0) &&
               ((bus.rfa_adr_i == pend_rd_q) || (bus.rfb_adr_i == pend_rd_q));
    hit_buf  = buf_valid_q && (buf_rd_q != '0) &&
               ((bus.rfa_adr_i == buf_rd_q) || (bus.rfb_adr_i == buf_rd_q));
  end

  assign bus.stall_o     = bus.rf_re_i && (hit_pend || hit_buf);
  assign bus.alu_ready_o = alu_ready;
  assign bus.ld_ready_o  = ld_ready;
  assign bus.rf_we_o     = rf_we_q;
  assign bus.rfd_adr_o   = rfd_adr_q;
  assign bus.result_o    = result_q;
  assign bus.state_o     = state_q;
  assign bus.pend_rd_o   = pend_rd_q;
endmodule

// File: doc/mor1kx_wb_arb_espresso.md
MOR1KX_WB_ARB_ESPRESSO -- requirements
Module: mor1kx_wb_arb_espresso

Interface
REQ-001 SHALL have parameter OPTION_RF_ADDR_WIDTH, default 5, GPR address width.
REQ-002 SHALL have parameter OPTION_OPERAND_WIDTH, default 32, result data width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alu_valid_i  input  1  single-cycle result wants writeback.
REQ-006 SHALL have port alu_rd_i  input  OPTION_RF_ADDR_WIDTH  ALU destination GPR.
REQ-007 SHALL have port alu_result_i  input  OPTION_OPERAND_WIDTH  ALU result.
REQ-008 SHALL have port alu_ready_o  output  1  ALU result accepted this cycle when high with alu_valid_i.
REQ-009 SHALL have port ld_issue_i  input  1  load issued to LSU.
REQ-010 SHALL have port ld_rd_i  input  OPTION_RF_ADDR_WIDTH  load destination GPR.
REQ-011 SHALL have port ld_ready_o  output  1  new load issue may be accepted.
REQ-012 SHALL have port lsu_ack_i  input  1  load data returned.
REQ-013 SHALL have port lsu_data_i  input  OPTION_OPERAND_WIDTH  load data.
REQ-014 SHALL have port flush_i  input  1  pipeline flush.
REQ-015 SHALL have ports rf_re_i (1), rfa_adr_i, rfb_adr_i (OPTION_RF_ADDR_WIDTH), inputs: decode read strobe and operand addresses.
REQ-016 SHALL have port stall_o  output  1  decode must hold (read hazard).
REQ-017 SHALL have ports rf_we_o (1), rfd_adr_o (OPTION_RF_ADDR_WIDTH), result_o (OPTION_OPERAND_WIDTH), outputs: registered writeback to register file.

Function
REQ-018 SHALL implement FSM states IDLE (no load outstanding), WAIT (one load outstanding, destination held in pend_rd), DRAIN (flushed load outstanding, data to be discarded).
REQ-019 SHALL transition IDLE->WAIT on ld_issue_i, capturing ld_rd_i into pend_rd.
REQ-020 SHALL in WAIT on lsu_ack_i schedule write of lsu_data_i to pend_rd; next state WAIT with new pend_rd if ld_issue_i same cycle, else IDLE.
REQ-021 SHALL in WAIT on flush_i without lsu_ack_i go to DRAIN; flush_i with lsu_ack_i SHALL complete the write and go IDLE.
REQ-022 SHALL in DRAIN discard lsu_ack_i data (no write) and go IDLE; ld_issue_i is not accepted in DRAIN.
REQ-023 SHALL drive ld_ready_o = (IDLE) or (WAIT and lsu_ack_i); ld_issue_i while ld_ready_o low SHALL be ignored; lsu_ack_i in IDLE SHALL be ignored.
REQ-024 SHALL hold a one-entry ALU skid buffer (buf_valid, buf_rd, buf_data).
REQ-025 SHALL drive alu_ready_o = !buf_valid and not (state WAIT and alu_rd_i == pend_rd), combinationally.
REQ-026 SHALL grant the single write slot per cycle by priority: load ack > buffered ALU > accepted incoming ALU; an accepted ALU result losing arbitration SHALL enter the buffer.
REQ-027 SHALL register the granted write: rf_we_o, rfd_adr_o, result_o valid exactly one cycle after the grant cycle; rf_we_o high for one cycle per write.
REQ-028 SHALL never assert rf_we_o for destination address 0; such writes are dropped but FSM/buffer bookkeeping proceeds normally.
REQ-029 SHALL drive stall_o = rf_re_i and (rfa_adr_i or rfb_adr_i matches a nonzero pend_rd in WAIT, or a nonzero buf_rd with buf_valid), combinationally.
REQ-030 SHALL not drop or cancel buffered ALU results on flush_i.

Reset
REQ-031 SHALL on rst high at a clock edge: state IDLE, pend_rd 0, buf_valid 0, rf_we_o 0, rfd_adr_o 0, result_o 0, regardless of other inputs; reset mid-load abandons it and a later lsu_ack_i is ignored.
REQ-032 SHALL after reset present alu_ready_o 1, ld_ready_o 1, stall_o 0.

Verification
REQ-033 ALU r3=0x11 cycle 0, no load -> cycle 1 rf_we_o=1, rfd_adr_o=3, result_o=0x11.
REQ-034 Load r5 issued, ack 0xAB same cycle as ALU r7=0x22 -> cycle+1 writes r5=0xAB, cycle+2 writes r7=0x22, alu_ready_o low during cycle+1.
REQ-035 Load r4 pending, rf_re_i with rfb_adr_i=4 -> stall_o=1 until ack cycle; ALU r4 held (alu_ready_o=0) until ack.
REQ-036 Load r6 pending, flush_i, later ack 0x55 -> no write to r6, state IDLE, ld_ready_o=1.
REQ-037 ALU to r0 with 0xFF -> rf_we_o stays 0; load r9 ack back-to-back with new load r10 issue -> r9 written, state stays WAIT, pend_rd=10.
REQ-038 rst asserted while WAIT and buf_valid -> next cycle all outputs at reset values, subsequent lsu_ack_i causes no write.
